// File: rtl/am2940_sequencer.sv
// Host-side sequencer that programs an am2940 DMA address generator, verifies
// the loaded word count, runs the transfer and reports success or error.
module am2940_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       resetneg,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] addr,
  input  logic [7:0] count,
  output logic       busy,
  output logic       xfer_ok,
  output logic       xfer_err,
  output logic [2:0] instr,
  output logic [7:0] am_din,
  input  logic [7:0] am_dout,
  output logic       acineg,
  output logic       wcineg,
  input  logic       done
);

  typedef enum logic [3:0] {
    IDLE, WR_CR, LD_ADDR, LD_WC, RD_WC, CHK, RUN, FIN, ERR
  } state_t;

  localparam logic [2:0] I_WRITE_CR  = 3'b000;
  localparam logic [2:0] I_READ_CR   = 3'b001;
  localparam logic [2:0] I_READ_WC   = 3'b010;
  localparam logic [2:0] I_LOAD_ADDR = 3'b101;
  localparam logic [2:0] I_LOAD_WC   = 3'b110;
  localparam logic [2:0] I_ENABLE    = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = '1;
  // RUN cycle k sees cnt == k, so the last permitted cycle is TIMEOUT-1.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      cap_mode_q, cap_mode_d;
  logic [7:0]      cap_addr_q, cap_addr_d;
  logic [7:0]      cap_count_q, cap_count_d;

  logic [2:0]      instr_d;
  logic [7:0]      din_d;
  logic            carry_n_d;
  logic            busy_d;
  logic            ok_d;
  logic            err_d;

  // Outputs are decoded from the current state and registered, so the pins
  // trail the state by one clock.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_mode_d  = cap_mode_q;
    cap_addr_d  = cap_addr_q;
    cap_count_d = cap_count_q;
    instr_d     = I_READ_CR;
    din_d       = '0;
    carry_n_d   = 1'b1;
    busy_d      = (state_q != IDLE);
    ok_d        = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cap_mode_d  = mode;
          cap_addr_d  = addr;
          cap_count_d = count;
          state_d     = WR_CR;
        end
      end
      WR_CR: begin
        instr_d = I_WRITE_CR;
        din_d   = {6'b0, cap_mode_q};
        state_d = LD_ADDR;
      end
      LD_ADDR: begin
        instr_d = I_LOAD_ADDR;
        din_d   = cap_addr_q;
        state_d = LD_WC;
      end
      LD_WC: begin
        instr_d = I_LOAD_WC;
        din_d   = cap_count_q;
        state_d = RD_WC;
      end
      RD_WC: begin
        instr_d = I_READ_WC;
        state_d = CHK;
      end
      CHK: begin
        instr_d = I_READ_WC;
        if (am_dout != cap_count_q) begin
          state_d = ERR;
        end else begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        instr_d   = I_ENABLE;
        carry_n_d = 1'b0;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Mode 3 never raises done, so the run length comes from the count.
        if (cap_mode_q == 2'd3) begin
          if (cnt_q == CW'(cap_count_q)) state_d = FIN;
        end else if (done) begin
          state_d = FIN;
        end else if (cnt_q >= TO_LAST) begin
          state_d = ERR;
        end
      end
      FIN: begin
        ok_d    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetneg) begin
    if (!resetneg) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_mode_q  <= '0;
      cap_addr_q  <= '0;
      cap_count_q <= '0;
      instr       <= I_READ_CR;
      am_din      <= '0;
      acineg      <= 1'b1;
      wcineg      <= 1'b1;
      busy        <= 1'b0;
      xfer_ok     <= 1'b0;
      xfer_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_mode_q  <= cap_mode_d;
      cap_addr_q  <= cap_addr_d;
      cap_count_q <= cap_count_d;
      instr       <= instr_d;
      am_din      <= din_d;
      acineg      <= carry_n_d;
      wcineg      <= carry_n_d;
      busy        <= busy_d;
      xfer_ok     <= ok_d;
      xfer_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_am2940_sequencer.sv
// Self-checking bench for am2940_sequencer: directed corner cases plus random
// transfers, each compared cycle by cycle against a trace built from the rules.
module tb_am2940_sequencer;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       resetneg;
  logic       start;
  logic [1:0] mode;
  logic [7:0] addr;
  logic [7:0] count;
  logic       busy;
  logic       xfer_ok;
  logic       xfer_err;
  logic [2:0] instr;
  logic [7:0] am_din;
  logic [7:0] am_dout;
  logic       acineg;
  logic       wcineg;
  logic       done;

  int total = 0;
  int bad   = 0;

  am2940_sequencer #(.TIMEOUT(TO), .CW(8)) dut (
    .clk      (clk),
    .resetneg (resetneg),
    .start    (start),
    .mode     (mode),
    .addr     (addr),
    .count    (count),
    .busy     (busy),
    .xfer_ok  (xfer_ok),
    .xfer_err (xfer_err),
    .instr    (instr),
    .am_din   (am_din),
    .am_dout  (am_dout),
    .acineg   (acineg),
    .wcineg   (wcineg),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] instr;
    logic [7:0] din;
    bit         chk_din;
    logic       carry_n;
    logic       busy;
    logic       ok;
    logic       err;
  } step_t;

  function automatic step_t mk(logic [2:0] i, logic [7:0] dn, bit cd,
                               logic cn, logic b, logic o, logic e);
    step_t s;
    s.instr = i; s.din = dn; s.chk_din = cd; s.carry_n = cn;
    s.busy = b; s.ok = o; s.err = e;
    return s;
  endfunction

  task automatic check_output(input string tag, input logic [7:0] obs,
                              input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "/instr"},  {5'b0, instr}, 8'h01);
    check_output({tag, "/am_din"}, am_din, 8'h00);
    check_output({tag, "/acineg"}, {7'b0, acineg}, 8'h01);
    check_output({tag, "/wcineg"}, {7'b0, wcineg}, 8'h01);
    check_output({tag, "/busy"},   {7'b0, busy}, 8'h00);
    check_output({tag, "/ok"},     {7'b0, xfer_ok}, 8'h00);
    check_output({tag, "/err"},    {7'b0, xfer_err}, 8'h00);
  endtask

  // One full transfer. The am2940 side returns dout on readback and raises
  // done once it has seen d cycles of ENABLE (modes 0-2 only).
  task automatic apply_stimulus(input string name, input logic [1:0] m,
                                input logic [7:0] a, input logic [7:0] c,
                                input logic [7:0] dout, input int d,
                                input bit poke_start, input bit poke_done);
    step_t q[$];
    int    r;
    bit    success, ok_exp;
    int    seen;
    string t;

    success = (dout == c);
    if (!success)          r = 0;
    else if (m == 2'd3)    r = int'(c) + 1;
    else if (d + 1 <= TO)  r = d + 1;
    else                   r = TO;
    ok_exp = success && (m == 2'd3 || d + 1 <= TO);

    q.push_back(mk(3'b001, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(3'b000, {6'b0, m}, 1, 1'b1, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(3'b101, a, 1, 1'b1, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(3'b110, c, 1, 1'b1, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(3'b010, 8'h00, 1, 1'b1, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(3'b010, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < r; i++)
      q.push_back(mk(3'b111, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(3'b001, 8'h00, 0, 1'b1, 1'b1, ok_exp, !ok_exp));
    q.push_back(mk(3'b001, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1'b0));

    @(negedge clk);
    start = 1'b1; mode = m; addr = a; count = c; am_dout = dout; done = 1'b0;
    seen = 0;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      t = $sformatf("%s[%0d]", name, k);
      check_output({t, "/instr"},  {5'b0, instr}, {5'b0, q[k].instr});
      check_output({t, "/acineg"}, {7'b0, acineg}, {7'b0, q[k].carry_n});
      check_output({t, "/wcineg"}, {7'b0, wcineg}, {7'b0, q[k].carry_n});
      check_output({t, "/busy"},   {7'b0, busy}, {7'b0, q[k].busy});
      check_output({t, "/ok"},     {7'b0, xfer_ok}, {7'b0, q[k].ok});
      check_output({t, "/err"},    {7'b0, xfer_err}, {7'b0, q[k].err});
      if (q[k].chk_din) check_output({t, "/am_din"}, am_din, q[k].din);
      start = 1'b0;
      done  = 1'b0;
      if (poke_start && k == 2) begin
        start = 1'b1; mode = ~m; addr = ~a; count = ~c;
      end
      if (poke_done && k == 1) done = 1'b1;
      if (m != 2'd3 && instr === 3'b111) begin
        seen++;
        if (seen >= d) done = 1'b1;
      end
    end
    done = 1'b0;
  endtask

  initial begin
    logic [1:0] rm;
    logic [7:0] ra, rc, rd;
    bit         found;

    start = 1'b0; mode = '0; addr = '0; count = '0; am_dout = '0; done = 1'b0;
    resetneg = 1'b1;
    #1 resetneg = 1'b0;
    #2 check_idle("reset");
    repeat (2) @(negedge clk);
    resetneg = 1'b1;

    apply_stimulus("mode0_ok",   2'd0, 8'hAA, 8'd3,  8'd3,  2,   0, 0);
    apply_stimulus("mismatch",   2'd0, 8'h12, 8'h55, 8'h54, 2,   0, 0);
    apply_stimulus("timeout",    2'd1, 8'h34, 8'h09, 8'h09, 100, 0, 0);
    apply_stimulus("done_at_to", 2'd2, 8'h56, 8'h20, 8'h20, TO - 1, 0, 0);
    apply_stimulus("mode3_c4",   2'd3, 8'h78, 8'd4,  8'd4,  1,   0, 0);
    apply_stimulus("mode3_c0",   2'd3, 8'h9A, 8'd0,  8'd0,  1,   0, 0);
    apply_stimulus("start_busy", 2'd2, 8'hC3, 8'd7,  8'd7,  3,   1, 0);
    apply_stimulus("done_early", 2'd0, 8'h0F, 8'd2,  8'd2,  1,   0, 1);

    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rc = (rm == 2'd3) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      rd = ($urandom_range(0, 3) == 0) ? (rc ^ (8'h01 << $urandom_range(0, 7))) : rc;
      apply_stimulus($sformatf("rand%0d", i), rm, ra, rc, rd,
                     int'($urandom_range(1, 10)),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    @(negedge clk);
    start = 1'b1; mode = 2'd3; addr = 8'h10; count = 8'd40; am_dout = 8'd40;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (instr === 3'b111) found = 1'b1;
    end
    check_output("rst_reach_run", {7'b0, found}, 8'h01);
    #2 resetneg = 1'b0;
    #1 check_idle("rst_in_run");
    @(negedge clk);
    resetneg = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("after_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/am2940_sequencer.md
Name: am2940_sequencer

Overview:
- Initiator-side controller that programs and runs an am2940 DMA address generator on behalf of a host.
- On a host start request it issues the am2940 instruction sequence: write control register, load address, load word count, read back the word counter for verification, then enable counters.
- It then waits for the am2940 completion (done) and reports success or error to the host.
- It sits between the host/bus-master logic and the am2940 instr/data_in/acineg/wcineg pins.

Parameters:
- TIMEOUT, 255: maximum RUN cycles without done before the error exit (modes 0-2).
- CW, 8: width of the internal timeout/run counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetneg  input  1  asynchronous, active-low reset.
- start  input  1  host request; sampled only in IDLE.
- mode  input  2  am2940 control-register mode (0..3); captured on start.
- addr  input  8  initial DMA address; captured on start.
- count  input  8  initial word count; captured on start.
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- xfer_ok  output  1  one-cycle pulse on successful completion.
- xfer_err  output  1  one-cycle pulse on readback mismatch or timeout.
- instr  output  3  am2940 instruction bus.
- am_din  output  8  data driven to the am2940 data_in.
- am_dout  input  8  am2940 data_out, used for readback.
- acineg  output  1  am2940 address carry-in; active low.
- wcineg  output  1  am2940 word carry-in; active low.
- done  input  1  am2940 DONE.

Behaviour:
- Instruction encoding:
  - 000 WRITE CR, 001 READ CR, 010 READ WC, 011 READ AC.
  - 100 REINIT, 101 LOAD ADDR, 110 LOAD WC, 111 ENABLE.
- Reset (asynchronous, resetneg=0): state=IDLE, instr=001, am_din=0, acineg=1, wcineg=1, busy=0, xfer_ok=0, xfer_err=0, internal counter=0, captured regs=0.
- IDLE outputs: instr=001 (non-destructive), am_din=0, acineg=wcineg=1.
- All outputs are registered. Each programming state lasts exactly one clock. instr and am_din change together and are held for that clock.
- IDLE:
  - start=1 captures mode/addr/count; go to WR_CR.
  - start is ignored when not in IDLE.
- WR_CR: instr=000, am_din={6'b0,mode}. Go to LD_ADDR.
- LD_ADDR: instr=101, am_din=addr. Go to LD_WC.
- LD_WC: instr=110, am_din=count. Go to RD_WC.
- RD_WC: instr=010, am_din=0. Go to CHK.
- CHK: instr=010 held; compare am_dout with captured count.
  - Mismatch: go to ERR.
  - Match: clear counter; go to RUN.
- RUN:
  - Outputs: instr=111, acineg=0, wcineg=0, counter increments each cycle.
  - Modes 0-2: done=1 goes to FIN. If counter reaches TIMEOUT first, go to ERR. If done and timeout occur in the same cycle, done wins.
  - Mode 3 (no done generation): go to FIN when counter equals captured count, i.e. RUN lasts count+1 cycles. count=0 gives a one-cycle RUN.
- FIN: instr=001, acineg=wcineg=1, xfer_ok=1 for one cycle. Go to IDLE.
- ERR: instr=001, acineg=wcineg=1, xfer_err=1 for one cycle. Go to IDLE.
- busy=1 in every state except IDLE. xfer_ok/xfer_err are never both high.
- Latency: start accepted at edge N gives the first ENABLE (instr=111) at edge N+6.
- Counter saturates at 2^CW-1; no wrap-around.
- resetneg asserted mid-sequence (including RUN): immediate return to reset values; acineg/wcineg go high asynchronously; no xfer_ok/xfer_err pulse.
- done while not in RUN: ignored.
- start held high continuously: a new transfer begins on the cycle after FIN/ERR returns to IDLE.

Test Plan:
- Reset:
  - Stimulus: resetneg=0 while in RUN.
  - Required: instr=001, acineg=wcineg=1, busy=0 before the next clk edge.
- Mode 0 success:
  - Stimulus: mode=0, addr=8'hAA, count=3; bench model returns am_dout=3 in CHK; done raised on the 3rd RUN cycle.
  - Required: instr sequence 000,101,110,010,010,111×3,001 with am_din 00,AA,03; xfer_ok pulses once; busy falls after FIN.
- Readback mismatch:
  - Stimulus: count=8'h55, am_dout=8'h54 in CHK.
  - Required: no 111 ever issued; xfer_err pulses one cycle; return to IDLE.
- Timeout:
  - Stimulus: TIMEOUT=8, mode=1, done never asserted.
  - Required: exactly 8 RUN cycles of instr=111, then xfer_err; acineg/wcineg return to 1.
- Mode 3:
  - Stimulus: count=4, done tied 0.
  - Required: 5 RUN cycles, then xfer_ok.
- Mode 3 boundary:
  - Stimulus: count=0.
  - Required: 1 RUN cycle, then xfer_ok.
- Start during busy:
  - Stimulus: start pulsed in LD_WC.
  - Required: ignored; captured addr/count unchanged; the transfer completes normally.
